// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: NOP encoding, J/JAL opcodes, default vectors.
package fetch_stage_pkg;

    localparam logic [31:0] NOP                = 32'h0000_0000;
    localparam logic [5:0]  OP_J               = 6'h02;
    localparam logic [5:0]  OP_JAL             = 6'h03;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: imem port, stall/redirect requests and the IF/ID outputs.
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        id_redirect;
    logic [31:0] id_target;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        exc_req;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;
    logic        ifid_jump_taken;

    modport master (
        output imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_jump_taken,
        input  imem_instr, stall, id_redirect, id_target, ex_redirect, ex_target, exc_req
    );

    modport slave (
        input  imem_addr, ifid_valid, ifid_pc, ifid_pc_plus4, ifid_instr, ifid_jump_taken,
        output imem_instr, stall, id_redirect, id_target, ex_redirect, ex_target, exc_req
    );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and flush; flush has priority over load.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump_taken,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_jump_taken
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_valid      <= 1'b0;
            ifid_pc         <= 32'h0;
            ifid_pc_plus4   <= 32'h0;
            ifid_instr      <= NOP;
            ifid_jump_taken <= 1'b0;
        end else if (flush) begin
            // PC fields are left as-is; only valid/instr/jump_taken carry meaning once flushed.
            ifid_valid      <= 1'b0;
            ifid_instr      <= NOP;
            ifid_jump_taken <= 1'b0;
        end else if (load) begin
            ifid_valid      <= 1'b1;
            ifid_pc         <= pc;
            ifid_pc_plus4   <= pc_plus4;
            ifid_instr      <= instr;
            ifid_jump_taken <= jump_taken;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// Optional J/JAL predecode redirect is enabled by defining FETCH_JUMP_PREDECODE_EN.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic        is_jump;
    logic        flush;
    logic        load;

    assign pc_plus4      = pc_q + 32'd4;
    assign bus.imem_addr = pc_q;

`ifdef FETCH_JUMP_PREDECODE_EN
    // Predecode only when nothing older or from ID wants the PC this cycle.
    assign is_jump = ((bus.imem_instr[31:26] == OP_J) || (bus.imem_instr[31:26] == OP_JAL)) &&
                     !bus.exc_req && !bus.ex_redirect && !bus.id_redirect && !bus.stall;
    assign jump_target = {pc_plus4[31:28], bus.imem_instr[25:0], 2'b00};
`else
    assign is_jump     = 1'b0;
    assign jump_target = pc_plus4;
`endif

    always_comb begin
        pc_d = pc_plus4;
        if (bus.exc_req) begin
            pc_d = EXC_VECTOR;
        end else if (bus.ex_redirect) begin
            pc_d = word_align(bus.ex_target);
        end else if (bus.id_redirect && !bus.stall) begin
            pc_d = word_align(bus.id_target);
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (is_jump) begin
            pc_d = jump_target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // EX and exception flushes win over stall; an ID redirect only acts once the stall clears.
    assign flush = bus.exc_req || bus.ex_redirect || (bus.id_redirect && !bus.stall);
    assign load  = !flush && !bus.stall;

    fetch_stage_if_id_reg u_if_id_reg (
        .clk             (clk),
        .reset           (reset),
        .load            (load),
        .flush           (flush),
        .pc              (pc_q),
        .pc_plus4        (pc_plus4),
        .instr           (bus.imem_instr),
        .jump_taken      (is_jump),
        .ifid_valid      (bus.ifid_valid),
        .ifid_pc         (bus.ifid_pc),
        .ifid_pc_plus4   (bus.ifid_pc_plus4),
        .ifid_instr      (bus.ifid_instr),
        .ifid_jump_taken (bus.ifid_jump_taken)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a cycle model pushes expected state, compared after each edge.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] instr;
        logic        jt;
    } st_t;

    st_t m;
    st_t exp_q[$];
    int unsigned n_checks;
    int unsigned n_pass;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0151_2000;
        if (a == 32'h0000_0020) return 32'h0800_0010;
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    assign bus.imem_instr = imem_fn(bus.imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, obs, exp);
    endtask

    function automatic st_t model_next(input st_t s, input logic stl, input logic idr,
                                       input logic [31:0] idt, input logic exr,
                                       input logic [31:0] ext, input logic exc);
        st_t         n   = s;
        logic [31:0] ins = imem_fn(s.pc);
        logic [31:0] seq = s.pc + 32'd4;
        logic        jmp = 1'b0;
`ifdef FETCH_JUMP_PREDECODE_EN
        jmp = ((ins[31:26] == 6'h02) || (ins[31:26] == 6'h03)) && !stl && !idr && !exr && !exc;
`endif
        if (exc)              n.pc = 32'h0000_0080;
        else if (exr)         n.pc = ext & 32'hFFFF_FFFC;
        else if (idr && !stl) n.pc = idt & 32'hFFFF_FFFC;
        else if (stl)         n.pc = s.pc;
        else if (jmp)         n.pc = {seq[31:28], ins[25:0], 2'b00};
        else                  n.pc = seq;
        if (exc || exr || (idr && !stl)) begin
            n.valid = 1'b0;
            n.instr = 32'h0;
            n.jt    = 1'b0;
        end else if (!stl) begin
            n.valid = 1'b1;
            n.ipc   = s.pc;
            n.ipc4  = seq;
            n.instr = ins;
            n.jt    = jmp;
        end
        return n;
    endfunction

    // Called just after an edge: drive inputs, predict, clock, then compare.
    task automatic cycle(input logic stl, input logic idr, input logic [31:0] idt,
                         input logic exr, input logic [31:0] ext, input logic exc);
        st_t e;
        bus.stall       = stl;
        bus.id_redirect = idr;
        bus.id_target   = idt;
        bus.ex_redirect = exr;
        bus.ex_target   = ext;
        bus.exc_req     = exc;
        m = model_next(m, stl, idr, idt, exr, ext, exc);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("pc", bus.imem_addr, e.pc);
        check_eq("valid", 32'(bus.ifid_valid), 32'(e.valid));
        check_eq("instr", bus.ifid_instr, e.instr);
        check_eq("jump_taken", 32'(bus.ifid_jump_taken), 32'(e.jt));
        if (e.valid) begin
            check_eq("ifid_pc", bus.ifid_pc, e.ipc);
            check_eq("ifid_pc_plus4", bus.ifid_pc_plus4, e.ipc4);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.id_redirect = 1'b0;
        bus.id_target   = 32'h0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = 32'h0;
        bus.exc_req     = 1'b0;
        m               = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pc", bus.imem_addr, 32'h0);
        check_eq("rst_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("rst_ifid_pc", bus.ifid_pc, 32'h0);
        check_eq("rst_ifid_pc4", bus.ifid_pc_plus4, 32'h0);
        check_eq("rst_instr", bus.ifid_instr, 32'h0);
        check_eq("rst_jt", 32'(bus.ifid_jump_taken), 32'h0);
        reset = 1'b0;

        // First fetch right after reset release
        idle(1);
        check_eq("first_instr", bus.ifid_instr, 32'h0151_2000);
        check_eq("first_valid", 32'(bus.ifid_valid), 32'h1);
        check_eq("first_addr", bus.imem_addr, 32'h4);
        idle(1);
        check_eq("at_pc8", bus.imem_addr, 32'h8);

        // Stall holds PC and IF/ID
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check_eq("stall_addr", bus.imem_addr, 32'h8);
        check_eq("stall_ifid_pc", bus.ifid_pc, 32'h4);
        idle(1);
        check_eq("unstall_addr", bus.imem_addr, 32'hC);

        // EX redirect overrides stall, target aligned
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0041, 1'b0);
        check_eq("exr_addr", bus.imem_addr, 32'h40);
        check_eq("exr_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("exr_instr", bus.ifid_instr, 32'h0);
        idle(2);

        // ID redirect ignored under stall, taken after
        cycle(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0);
        check_eq("idr_stalled", bus.imem_addr, 32'h48);
        cycle(1'b0, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0);
        check_eq("idr_addr", bus.imem_addr, 32'h100);
        check_eq("idr_valid", 32'(bus.ifid_valid), 32'h0);
        idle(1);

        // Exception has top priority
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h300, 1'b1);
        check_eq("exc_addr", bus.imem_addr, 32'h80);
        check_eq("exc_valid", 32'(bus.ifid_valid), 32'h0);

        // PC wrap
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check_eq("top_addr", bus.imem_addr, 32'hFFFF_FFFC);
        idle(1);
        check_eq("wrap_addr", bus.imem_addr, 32'h0);
        check_eq("wrap_ifid_pc4", bus.ifid_pc_plus4, 32'h0);

        // J at 0x20
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h20, 1'b0);
        idle(1);
        check_eq("j_instr", bus.ifid_instr, 32'h0800_0010);
`ifdef FETCH_JUMP_PREDECODE_EN
        check_eq("j_addr", bus.imem_addr, 32'h40);
        check_eq("j_taken", 32'(bus.ifid_jump_taken), 32'h1);
`else
        check_eq("j_addr", bus.imem_addr, 32'h24);
        check_eq("j_taken", 32'(bus.ifid_jump_taken), 32'h0);
`endif

        for (int i = 0; i < 300; i++) begin
            cycle(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom,
                  ($urandom % 10) == 0, $urandom, ($urandom % 20) == 0);
        end

        // Asynchronous reset mid-cycle
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_rst_pc", bus.imem_addr, 32'h0);
        check_eq("async_rst_valid", 32'(bus.ifid_valid), 32'h0);
        check_eq("async_rst_instr", bus.ifid_instr, 32'h0);
        m = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        check_eq("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
